// File: rtl/rvz_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// rvz_fetch_ctrl
//
// Fetch sequencer for the RISC-V Zero front end. Generates the fetch PC,
// issues instruction-memory requests on a valid/ready channel, pairs the
// in-order responses with their PCs and buffers them in a small queue that
// feeds decode. A branch redirect retargets the PC, flushes the queue and
// marks every in-flight request for discard.
//
// Parameters
//   FIFO_DEPTH  instruction queue entries; also caps outstanding + queued
//               (power of two, >= 2)
//   RESET_PC    fetch address after reset
//
// Ports
//   clk             clock, all state on rising edge
//   reset           synchronous active-low reset
//   redirect_valid  one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc     redirect target, bits [1:0] ignored
//   imem_req_valid  request valid (credit available and no redirect)
//   imem_req_ready  memory accepts request
//   imem_req_addr   request address (= fetch_pc)
//   imem_rsp_valid  response word valid (in request order)
//   imem_rsp_data   instruction word
//   inst_valid      queue head valid to decode
//   inst_ready      decode accepts head
//   inst_pc         PC of head instruction
//   inst_data       head instruction word
// -----------------------------------------------------------------------------
module rvz_fetch_ctrl #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] inst_pc,
  output logic [31:0] inst_data
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  logic [63:0]   fetch_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_cnt;

  // Tag queue: one PC per outstanding request, in request order.
  logic [63:0]   tag_mem [FIFO_DEPTH];
  logic [PW-1:0] tag_wr;
  logic [PW-1:0] tag_rd;

  // Instruction queue: {pc, data} pairs waiting for decode.
  logic [63:0]   iq_pc   [FIFO_DEPTH];
  logic [31:0]   iq_data [FIFO_DEPTH];
  logic [PW-1:0] iq_wr;
  logic [PW-1:0] iq_rd;

  logic [CW:0]   in_flight;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          inst_pop;
  logic [CW-1:0] out_cnt_nxt;
  logic [CW-1:0] q_cnt_nxt;
  logic [CW-1:0] drop_on_redirect;

  logic          unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit counts queued words even if decode pops them this cycle, so the
  // decision depends only on registered state and redirect_valid.
  assign in_flight      = {1'b0, out_cnt} + {1'b0, q_cnt};
  assign imem_req_valid = (in_flight < CREDIT_MAX) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;

  assign inst_valid = (q_cnt != CNT_ZERO);
  assign inst_pc    = iq_pc[iq_rd];
  assign inst_data  = iq_data[iq_rd];

  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol violation; ignore it.
  assign rsp_fire = imem_rsp_valid && (out_cnt != CNT_ZERO);
  assign rsp_keep = rsp_fire && (drop_cnt == CNT_ZERO) && !redirect_valid;
  assign inst_pop = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    out_cnt_nxt = out_cnt;
    if (req_fire) out_cnt_nxt = out_cnt_nxt + CNT_ONE;
    if (rsp_fire) out_cnt_nxt = out_cnt_nxt - CNT_ONE;
  end

  always_comb begin
    q_cnt_nxt = q_cnt;
    if (rsp_keep) q_cnt_nxt = q_cnt_nxt + CNT_ONE;
    if (inst_pop) q_cnt_nxt = q_cnt_nxt - CNT_ONE;
  end

  // On redirect every request still outstanding after this cycle belongs to
  // the old path; a response arriving in the redirect cycle is dropped
  // directly and so is not counted.
  always_comb begin
    drop_on_redirect = out_cnt;
    if (rsp_fire) drop_on_redirect = out_cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      q_cnt    <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      iq_wr    <= '0;
      iq_rd    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_mem[i] <= '0;
        iq_pc[i]   <= '0;
        iq_data[i] <= '0;
      end
    end else begin
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[63:2], 2'b00};
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 64'd4;
      end

      if (req_fire) begin
        tag_mem[tag_wr] <= fetch_pc;
        tag_wr          <= tag_wr + PTR_ONE;
      end
      if (rsp_fire) begin
        tag_rd <= tag_rd + PTR_ONE;
      end
      out_cnt <= out_cnt_nxt;

      if (redirect_valid) begin
        drop_cnt <= drop_on_redirect;
      end else if (rsp_fire && (drop_cnt != CNT_ZERO)) begin
        drop_cnt <= drop_cnt - CNT_ONE;
      end

      if (redirect_valid) begin
        q_cnt <= '0;
        iq_wr <= '0;
        iq_rd <= '0;
      end else begin
        if (rsp_keep) begin
          iq_pc[iq_wr]   <= tag_mem[tag_rd];
          iq_data[iq_wr] <= imem_rsp_data;
          iq_wr          <= iq_wr + PTR_ONE;
        end
        if (inst_pop) begin
          iq_rd <= iq_rd + PTR_ONE;
        end
        q_cnt <= q_cnt_nxt;
      end
    end
  end

endmodule
